// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl
// Raster sequencer for the HDMI TX path. Produces the h/v counters, pixel
// coordinates, line/frame strobes and sync/DE. A three-state controller makes
// start and stop frame-aligned. Sync/DE go through a short delay line so they
// line up with the pixel generator's pipelined RGB at hdmi_tx.

module video_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIPE_DLY = 2
) (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic        enable,
    output logic        running,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        pix_valid,
    output logic        line_start,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [15:0] frame_cnt
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Last counter values of a line / frame.
    localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);

    // Region boundaries are held one bit wider than the counters so an end
    // boundary equal to 1024 (zero back porch on a full-width raster) does not
    // wrap to zero and empty the window.
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG    = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    // Values the delayed outputs hold while idle or in reset: {hsync, vsync, de}.
    localparam logic [2:0] INACTIVE_VEC = {~HS_POL, ~VS_POL, 1'b0};

    // Counters are fixed at 10 bits; refuse to elaborate a raster that does not fit.
    if (H_TOT > 1024 || V_TOT > 1024) begin : g_size_chk
        $error("video_timing_ctrl: H_TOT/V_TOT must not exceed 1024");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 8) begin : g_dly_chk
        $error("video_timing_ctrl: PIPE_DLY must be within 0..8");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [9:0]  h_reg;
    logic [9:0]  v_reg;
    logic [15:0] frame_cnt_reg;

    logic        active;
    logic        end_of_line;
    logic        end_of_frame;
    logic        h_in_act;
    logic        v_in_act;
    logic        hs_act;
    logic        vs_act;
    logic        hs_raw;
    logic        vs_raw;
    logic        pv_raw;
    logic [2:0]  raw_vec;
    logic [2:0]  dly_vec;

    assign active       = (state_reg != ST_IDLE);
    assign end_of_line  = (h_reg == H_LAST);
    assign end_of_frame = end_of_line && (v_reg == V_LAST);

    // Controller state register.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. A stop request only takes effect once the frame in
    // flight has finished; re-enabling during STOP simply resumes RUN.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (enable) begin
                    state_next = ST_RUN;
                end else if (end_of_frame) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Raster counters: parked at 0 while idle so the first RUN cycle is the
    // top-left pixel, free-running in RUN and STOP.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            h_reg <= '0;
            v_reg <= '0;
        end else if (!active) begin
            h_reg <= '0;
            v_reg <= '0;
        end else if (end_of_line) begin
            h_reg <= '0;
            v_reg <= (v_reg == V_LAST) ? 10'd0 : v_reg + 10'd1;
        end else begin
            h_reg <= h_reg + 10'd1;
        end
    end

    // Completed-frame counter; wraps naturally at 16 bits.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg <= '0;
        end else if (active && end_of_frame) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    // Undelayed timing flags, all decoded from the registered counters.
    assign h_in_act = ({1'b0, h_reg} < H_ACT_END);
    assign v_in_act = ({1'b0, v_reg} < V_ACT_END);
    assign hs_act   = active && ({1'b0, h_reg} >= HS_BEG) && ({1'b0, h_reg} < HS_END);
    assign vs_act   = active && ({1'b0, v_reg} >= VS_BEG) && ({1'b0, v_reg} < VS_END);
    assign pv_raw   = active && h_in_act && v_in_act;
    assign hs_raw   = hs_act ? HS_POL : ~HS_POL;
    assign vs_raw   = vs_act ? VS_POL : ~VS_POL;
    assign raw_vec  = {hs_raw, vs_raw, pv_raw};

    // Delay line matching the pixel generator latency; depth 0 is a wire.
    generate
        if (PIPE_DLY == 0) begin : g_no_pipe
            assign dly_vec = raw_vec;
        end else begin : g_pipe
            logic [2:0] stage_reg [PIPE_DLY];

            // Shift {hsync, vsync, de} one stage per pixel clock.
            always_ff @(posedge clk_pixel or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE_DLY; i++) begin
                        stage_reg[i] <= INACTIVE_VEC;
                    end
                end else begin
                    stage_reg[0] <= raw_vec;
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                    end
                end
            end

            assign dly_vec = stage_reg[PIPE_DLY-1];
        end
    endgenerate

    assign running     = active;
    assign x           = h_reg;
    assign y           = v_reg;
    assign pix_valid   = pv_raw;
    assign line_start  = active && (h_reg == 10'd0);
    assign frame_start = active && (h_reg == 10'd0) && (v_reg == 10'd0);
    assign hsync       = dly_vec[2];
    assign vsync       = dly_vec[1];
    assign de          = dly_vec[0];
    assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb_video_timing_ctrl
// Directed bench for video_timing_ctrl. Three instances share one clock:
//   dut_a: 40x20 raster, no sync delay  (raster shape, stop/resume, async reset)
//   dut_b: 14x7 raster, 2-stage delay, active-high vsync (delay alignment)
//   dut_c: 1x1 raster, every cycle ends a frame (frame_cnt wrap)

module tb_video_timing_ctrl;

    // dut_a geometry
    localparam int A_HA = 20, A_HF = 4, A_HS = 6, A_HB = 10;
    localparam int A_VA = 10, A_VF = 2, A_VS = 3, A_VB = 5;
    localparam int A_HT = A_HA + A_HF + A_HS + A_HB;   // 40
    localparam int A_VT = A_VA + A_VF + A_VS + A_VB;   // 20
    // dut_b geometry
    localparam int B_HT = 14;
    localparam int B_VT = 7;

    if (A_HT > 1024 || A_VT > 1024 || B_HT > 1024 || B_VT > 1024) begin : g_size_chk
        $error("bench raster does not fit 10-bit counters");
    end

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, en_a, a_running, a_pix_valid, a_line_start, a_frame_start;
    logic        a_hsync, a_vsync, a_de;
    logic [9:0]  a_x, a_y;
    logic [15:0] a_frame_cnt;

    logic        rst_b_n, en_b, b_running, b_pix_valid, b_line_start, b_frame_start;
    logic        b_hsync, b_vsync, b_de;
    logic [9:0]  b_x, b_y;
    logic [15:0] b_frame_cnt;

    logic        rst_c_n, en_c, c_running, c_pix_valid, c_line_start, c_frame_start;
    logic        c_hsync, c_vsync, c_de;
    logic [9:0]  c_x, c_y;
    logic [15:0] c_frame_cnt;

    video_timing_ctrl #(
        .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(0)
    ) dut_a (
        .clk_pixel(clk), .rst_n(rst_a_n), .enable(en_a), .running(a_running),
        .x(a_x), .y(a_y), .pix_valid(a_pix_valid), .line_start(a_line_start),
        .frame_start(a_frame_start), .hsync(a_hsync), .vsync(a_vsync), .de(a_de),
        .frame_cnt(a_frame_cnt)
    );

    video_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .PIPE_DLY(2)
    ) dut_b (
        .clk_pixel(clk), .rst_n(rst_b_n), .enable(en_b), .running(b_running),
        .x(b_x), .y(b_y), .pix_valid(b_pix_valid), .line_start(b_line_start),
        .frame_start(b_frame_start), .hsync(b_hsync), .vsync(b_vsync), .de(b_de),
        .frame_cnt(b_frame_cnt)
    );

    video_timing_ctrl #(
        .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
        .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(1)
    ) dut_c (
        .clk_pixel(clk), .rst_n(rst_c_n), .enable(en_c), .running(c_running),
        .x(c_x), .y(c_y), .pix_valid(c_pix_valid), .line_start(c_line_start),
        .frame_start(c_frame_start), .hsync(c_hsync), .vsync(c_vsync), .de(c_de),
        .frame_cnt(c_frame_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // bench model position of dut_a and its error tallies
    int ax = 0, ay = 0;
    int a_err_xy = 0, a_not_run = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv_a();
        if (ax == A_HT - 1) begin
            ax = 0;
            ay = (ay == A_VT - 1) ? 0 : ay + 1;
        end else begin
            ax++;
        end
    endtask

    // step dut_a n cycles, comparing position with the model and expecting running
    task automatic walk_a(input int n);
        for (int i = 0; i < n; i++) begin
            if (a_x !== 10'(ax) || a_y !== 10'(ay)) a_err_xy++;
            if (a_running !== 1'b1) a_not_run++;
            tick();
            adv_a();
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_de, n_hs, n_vs, n_ls, n_fs, err_de, err_hs, err_vs, n_cyc, viol;
        int bx, by, t_pv, t_de, t_hx, t_hs, t_fs0, t_fs1, t_ls0, t_ls1;
        int e_pv, e_hs, e_vs, err_b;
        logic pv_d1, pv_d2, hs_d1, hs_d2, vs_d1, vs_d2;
        logic b_run;

        rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        repeat (3) tick();

        // ---- reset values ----
        check_val("a_rst_running", a_running, 0);
        check_val("a_rst_x", a_x, 0);
        check_val("a_rst_y", a_y, 0);
        check_val("a_rst_hsync", a_hsync, 1);
        check_val("a_rst_vsync", a_vsync, 1);
        check_val("a_rst_de", a_de, 0);
        check_val("a_rst_strobes", {a_line_start, a_frame_start, a_pix_valid}, 0);
        check_val("a_rst_frame_cnt", a_frame_cnt, 0);
        check_val("b_rst_hsync", b_hsync, 1);
        check_val("b_rst_vsync", b_vsync, 0);
        check_val("b_rst_de", b_de, 0);

        // ---- idle after release with enable low ----
        rst_a_n = 1'b1;
        repeat (3) tick();
        check_val("a_idle_running", a_running, 0);
        check_val("a_idle_x", a_x, 0);
        check_val("a_idle_fs", a_frame_start, 0);

        // ---- first RUN cycle ----
        en_a = 1'b1;
        tick();
        check_val("a_start_running", a_running, 1);
        check_val("a_start_xy", {a_y, a_x}, 0);
        check_val("a_start_fs", a_frame_start, 1);
        check_val("a_start_ls", a_line_start, 1);

        // ---- one full frame against the model ----
        ax = 0; ay = 0;
        n_de = 0; n_hs = 0; n_vs = 0; n_ls = 0; n_fs = 0;
        err_de = 0; err_hs = 0; err_vs = 0;
        for (int i = 0; i < A_HT * A_VT; i++) begin
            if (a_x !== 10'(ax) || a_y !== 10'(ay)) a_err_xy++;
            if ({a_de, a_pix_valid} !== {2{ax < A_HA && ay < A_VA}}) err_de++;
            if (a_hsync !== !(ax >= A_HA + A_HF && ax < A_HA + A_HF + A_HS)) err_hs++;
            if (a_vsync !== !(ay >= A_VA + A_VF && ay < A_VA + A_VF + A_VS)) err_vs++;
            n_de += int'(a_de);
            n_hs += int'(!a_hsync);
            n_vs += int'(!a_vsync);
            n_ls += int'(a_line_start);
            n_fs += int'(a_frame_start);
            tick();
            adv_a();
        end
        check_val("a_frame_xy_err", a_err_xy, 0);
        check_val("a_frame_de_cycles", n_de, 200);
        check_val("a_frame_hs_low_cycles", n_hs, 120);
        check_val("a_frame_vs_low_cycles", n_vs, 120);
        check_val("a_frame_line_starts", n_ls, 20);
        check_val("a_frame_frame_starts", n_fs, 1);
        check_val("a_frame_de_err", err_de, 0);
        check_val("a_frame_hs_err", err_hs, 0);
        check_val("a_frame_vs_err", err_vs, 0);
        check_val("a_period_fs", a_frame_start, 1);
        check_val("a_period_cnt", a_frame_cnt, 1);

        // ---- stop at line 4: raster runs to end of frame, then idles ----
        walk_a(4 * A_HT);
        check_val("a_stop_at_y", a_y, 4);
        en_a = 1'b0;
        n_cyc = 0;
        while (a_running === 1'b1 && n_cyc < 2000) begin
            if (a_x !== 10'(ax) || a_y !== 10'(ay)) a_err_xy++;
            tick();
            adv_a();
            n_cyc++;
        end
        check_val("a_stop_cycles_to_idle", n_cyc, 640);
        check_val("a_stop_xy_err", a_err_xy, 0);
        check_val("a_stop_frame_cnt", a_frame_cnt, 2);
        check_val("a_stop_xy", {a_y, a_x}, 0);
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            if (a_hsync !== 1'b1 || a_vsync !== 1'b1 || a_de !== 1'b0 || a_running !== 1'b0 ||
                a_x !== 10'd0 || a_frame_start !== 1'b0 || a_line_start !== 1'b0) viol++;
            tick();
        end
        check_val("a_idle_outputs_viol", viol, 0);
        check_val("a_idle_frame_cnt", a_frame_cnt, 2);

        // ---- resume: stop at line 4, re-enable at line 8, no gap ----
        en_a = 1'b1;
        tick();
        check_val("a_restart_fs", a_frame_start, 1);
        ax = 0; ay = 0;
        walk_a(4 * A_HT);
        en_a = 1'b0;
        walk_a(4 * A_HT);
        en_a = 1'b1;
        walk_a(12 * A_HT);
        check_val("a_resume_xy_err", a_err_xy, 0);
        check_val("a_resume_not_running", a_not_run, 0);
        check_val("a_resume_fs", a_frame_start, 1);
        check_val("a_resume_frame_cnt", a_frame_cnt, 3);

        // ---- asynchronous reset mid-frame (x=25, y=6, inside hsync) ----
        walk_a(6 * A_HT + 25);
        check_val("a_pre_rst_xy", {a_y, a_x}, {10'd6, 10'd25});
        check_val("a_pre_rst_hsync", a_hsync, 0);
        #2;
        rst_a_n = 1'b0;
        #1;
        check_val("a_async_running", a_running, 0);
        check_val("a_async_xy", {a_y, a_x}, 0);
        check_val("a_async_hsync", a_hsync, 1);
        check_val("a_async_frame_cnt", a_frame_cnt, 0);
        check_val("a_async_strobes", {a_de, a_line_start, a_frame_start}, 0);
        tick();
        rst_a_n = 1'b1;
        tick();
        check_val("a_rerun_running", a_running, 1);
        check_val("a_rerun_fs", a_frame_start, 1);
        tick();
        check_val("a_rerun_x", a_x, 1);
        check_val("a_rerun_fs_drop", a_frame_start, 0);

        // ---- dut_b: 2-cycle sync/de delay, 98-cycle frame ----
        rst_b_n = 1'b1;
        tick();
        en_b = 1'b1;
        bx = 0; by = 0; b_run = 1'b0;
        pv_d1 = 1'b0; pv_d2 = 1'b0; hs_d1 = 1'b1; hs_d2 = 1'b1; vs_d1 = 1'b0; vs_d2 = 1'b0;
        t_pv = -1; t_de = -1; t_hx = -1; t_hs = -1; t_fs0 = -1; t_fs1 = -1; t_ls0 = -1; t_ls1 = -1;
        err_b = 0;
        for (int t = 0; t < 3 * B_HT * B_VT + 3; t++) begin
            tick();
            if (!b_run) begin
                b_run = 1'b1;
            end else if (bx == B_HT - 1) begin
                bx = 0;
                by = (by == B_VT - 1) ? 0 : by + 1;
            end else begin
                bx++;
            end
            e_pv = int'(bx < 8 && by < 4);
            e_hs = int'(!(bx >= 10 && bx < 12));
            e_vs = int'(by >= 5 && by < 6);
            if (b_pix_valid !== e_pv[0] || b_de !== pv_d2 || b_hsync !== hs_d2 ||
                b_vsync !== vs_d2) err_b++;
            pv_d2 = pv_d1; pv_d1 = e_pv[0];
            hs_d2 = hs_d1; hs_d1 = e_hs[0];
            vs_d2 = vs_d1; vs_d1 = e_vs[0];
            if (t_pv < 0 && b_pix_valid === 1'b1) t_pv = t;
            if (t_de < 0 && b_de === 1'b1) t_de = t;
            if (t_hx < 0 && b_x === 10'd10) t_hx = t;
            if (t_hs < 0 && b_hsync === 1'b0) t_hs = t;
            if (b_frame_start === 1'b1) begin
                if (t_fs0 < 0) t_fs0 = t;
                else if (t_fs1 < 0) t_fs1 = t;
            end
            if (b_line_start === 1'b1) begin
                if (t_ls0 < 0) t_ls0 = t;
                else if (t_ls1 < 0) t_ls1 = t;
            end
        end
        check_val("b_delay_model_err", err_b, 0);
        check_val("b_de_after_pv", t_de - t_pv, 2);
        check_val("b_hs_after_x656eq", t_hs - t_hx, 2);
        check_val("b_first_fs", t_fs0, 0);
        check_val("b_fs_period", t_fs1 - t_fs0, 98);
        check_val("b_ls_period", t_ls1 - t_ls0, 14);
        check_val("b_frame_cnt", b_frame_cnt, 3);

        // ---- dut_c: one frame per cycle, frame_cnt wraps 0xFFFF -> 0 ----
        rst_c_n = 1'b1;
        tick();
        en_c = 1'b1;
        tick();
        check_val("c_start_running", c_running, 1);
        check_val("c_start_frame_cnt", c_frame_cnt, 0);
        repeat (65535) tick();
        check_val("c_cnt_ffff", c_frame_cnt, 16'hFFFF);
        tick();
        check_val("c_cnt_wrap", c_frame_cnt, 0);
        check_val("c_outputs", {c_de, c_frame_start, c_line_start, c_hsync, c_vsync, c_x, c_y},
                  {5'b11111, 20'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
